// File: rtl/eth_fcs_stream.sv
// Streaming Ethernet FCS engine: reflected CRC-32 over an AXI-Stream frame,
// one-stage data register slice, end-of-frame FCS/residue result, and
// saturating frame/error counters.
module eth_fcs_stream #(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*DATA_BYTES-1:0] s_tdata,
  input  logic [DATA_BYTES-1:0]   s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [8*DATA_BYTES-1:0] m_tdata,
  output logic [DATA_BYTES-1:0]   m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [31:0]             res_fcs,
  output logic                    res_ok,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CNT_W-1:0]        cnt_frames,
  output logic [CNT_W-1:0]        cnt_bad,
  input  logic                    cnt_clr
);

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;

  logic [31:0]           crc_q;
  logic [31:0]           crc_next;
  logic                  err_q;
  logic                  beat_err;
  logic                  accept;
  logic                  frame_done;
  logic                  ok_next;
  logic [DATA_BYTES-1:0] keep_inc;

  // One byte of reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned b = 0; b < 8; b++) begin
      r = (r[0] ^ d[b]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Input is held off while a result waits to be read, and during reset.
  assign s_tready   = !rst && (!m_tvalid || m_tready) && !(res_valid && !res_ready);
  assign accept     = s_tvalid && s_tready;
  assign frame_done = accept && s_tlast;

  // A contiguous-from-bit-0 keep plus one has no bits in common with itself.
  assign keep_inc = s_tkeep + DATA_BYTES'(1);

  // Beat is malformed if keep is non-contiguous, or partial on a non-last beat.
  always_comb begin
    beat_err = ((s_tkeep & keep_inc) != '0) || (!s_tlast && (s_tkeep != '1));
  end

  // Chained per-byte CRC update over the kept bytes of the current beat.
  always_comb begin
    crc_next = crc_q;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (s_tkeep[i]) crc_next = crc_byte(crc_next, s_tdata[8*i +: 8]);
    end
  end

  // Residue check for a frame closing on this beat.
  always_comb begin
    ok_next = (crc_next == RESIDUE) && !(err_q || beat_err);
  end

  // Data register slice: load on accept, hold valid until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
      m_tkeep  <= s_tkeep;
      m_tlast  <= s_tlast;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // Running CRC and malformed-beat flag; both restart after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC_INIT;
      err_q <= 1'b0;
    end else if (accept) begin
      if (s_tlast) begin
        crc_q <= CRC_INIT;
        err_q <= 1'b0;
      end else begin
        crc_q <= crc_next;
        err_q <= err_q || beat_err;
      end
    end
  end

  // End-of-frame result, held until read.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_fcs   <= '0;
      res_ok    <= 1'b0;
    end else if (frame_done) begin
      res_valid <= 1'b1;
      res_fcs   <= ~crc_next;
      res_ok    <= ok_next;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Saturating statistics; clear takes priority over a completing frame.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_frames <= '0;
      cnt_bad    <= '0;
    end else if (frame_done) begin
      if (cnt_frames != '1) cnt_frames <= cnt_frames + CNT_W'(1);
      if (!ok_next && (cnt_bad != '1)) cnt_bad <= cnt_bad + CNT_W'(1);
    end
  end

endmodule
